// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : WIDTH-bit two's-complement add/subtract built from one 4-bit
//               full-adder slice. The slice is sequenced LSB nibble first,
//               one nibble per clock, and the carry is held in a register
//               between steps. Operands arrive and results leave over
//               valid/ready handshakes.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_valid  in   operand request valid
//   start_ready  out  controller idle, can accept an operation
//   a, b         in   WIDTH-bit two's-complement operands
//   sub          in   0 = a+b, 1 = a-b
//   res_valid    out  result available
//   res_ready    in   consumer accepts result
//   sum          out  WIDTH-bit result
//   carryout     out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow     out  signed overflow of the full-width operation
//   busy         out  operation in progress or result pending
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);

    localparam int STEPS  = WIDTH / 4;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;      // effective operand: already inverted for subtract
    logic              carry_q, carry_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // 4-bit slice. The low three bits are added separately so the carry
    // into bit 3 is available for the signed-overflow term.
    // ------------------------------------------------------------------
    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] lo_sum;
    logic       c3;
    logic [3:0] slice_sum;
    logic       slice_cout;

    assign a_nib      = a_q[{step_q, 2'b00} +: 4];
    assign b_nib      = b_q[{step_q, 2'b00} +: 4];
    assign lo_sum     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    assign c3         = lo_sum[3];
    assign slice_sum  = {a_nib[3] ^ b_nib[3] ^ c3, lo_sum[2:0]};
    assign slice_cout = (a_nib[3] & b_nib[3]) | (c3 & (a_nib[3] ^ b_nib[3]));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        step_d  = step_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    // Subtract is A + ~B + 1: invert here, inject the +1
                    // through the initial carry.
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{step_q, 2'b00} +: 4] = slice_sum;
                carry_d = slice_cout;
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    cout_d  = slice_cout;
                    ovf_d   = c3 ^ slice_cout;
                    step_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum         = sum_q;
    assign carryout    = cout_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl (WIDTH=16 and
//               WIDTH=8 instances) with an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    localparam int STEPS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_valid, start_ready, sub, res_valid, res_ready;
    logic        carryout, overflow, busy;
    logic [15:0] a, b, sum;

    logic        sv8, sr8, sub8, rv8, rr8, co8, ov8, busy8;
    logic [7:0]  a8, b8, sum8;

    int checks   = 0;
    int failures = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .carryout(carryout), .overflow(overflow), .busy(busy)
    );

    nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .sub(sub8), .res_valid(rv8), .res_ready(rr8),
        .sum(sum8), .carryout(co8), .overflow(ov8), .busy(busy8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {overflow, carryout, sum} of a 16-bit add/subtract from plain arithmetic
    function automatic logic [17:0] calc(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] be;
        logic [16:0] t;
        logic        ov;
        be = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, be} + 17'(s);
        ov = (x[15] == be[15]) && (t[15] != x[15]);
        return {ov, t[16], t[15:0]};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: phase 0 = idle, 1 = computing, 2 = result held
    // ------------------------------------------------------------------
    int          m_phase;
    int          m_cnt;
    logic [17:0] m_pend;
    logic [15:0] m_sum;
    logic        m_co, m_ov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_pend  <= '0;
            m_sum   <= '0;
            m_co    <= 1'b0;
            m_ov    <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin
                    m_pend  <= calc(a, b, sub);
                    m_cnt   <= 1;
                    m_phase <= 1;
                end
                1: begin
                    if (m_cnt == STEPS) begin
                        {m_ov, m_co, m_sum} <= m_pend;
                        m_phase <= 2;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                default: if (res_ready) m_phase <= 0;
            endcase
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("start_ready", 32'(start_ready), 32'(m_phase == 0));
            chk("res_valid",   32'(res_valid),   32'(m_phase == 2));
            chk("busy",        32'(busy),        32'(m_phase != 0));
            chk("carryout",    32'(carryout),    32'(m_co));
            chk("overflow",    32'(overflow),    32'(m_ov));
            if (m_phase != 1) chk("sum", 32'(sum), 32'(m_sum));
        end
    end

    // ------------------------------------------------------------------
    // Directed operation with literal expectations
    // ------------------------------------------------------------------
    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                         input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int n;
        start_valid = 1'b1; a = xa; b = xb; sub = xs; res_ready = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0; a = 16'(~xa); b = 16'($urandom); sub = ~xs;
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"},  32'(n),        32'(4));
        chk({nm, "_sum"},      32'(sum),      32'(es));
        chk({nm, "_carryout"}, 32'(carryout), 32'(ec));
        chk({nm, "_overflow"}, 32'(overflow), 32'(eo));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({nm, "_idle"}, 32'(start_ready), 32'(1));
    endtask

    initial begin
        int n;
        logic [15:0] hs;
        rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; sub = 1'b0; res_ready = 1'b0;
        sv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; rr8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'(1));
        chk("rst_res_valid",   32'(res_valid),   32'(0));
        chk("rst_busy",        32'(busy),        32'(0));
        chk("rst_sum",         32'(sum),         32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add");
        run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "sovf");
        run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        run16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub1");
        run16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub2");

        // Backpressure with start requests during RUN and DONE
        start_valid = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1;   // keep requesting: must be ignored
        n = 0;
        while (!res_valid && n < 20) begin
            chk("bp_run_ready", 32'(start_ready), 32'(0));
            @(posedge clk); #1;
            n++;
        end
        hs = sum;
        chk("bp_sum", 32'(sum), 32'h5432);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(res_valid),   32'(1));
            chk("bp_hold_sum",   32'(sum),         32'(hs));
            chk("bp_hold_ready", 32'(start_ready), 32'(0));
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_release", 32'(start_ready), 32'(1));

        // Asynchronous reset in the middle of RUN
        start_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",    32'(start_ready), 32'(1));
        chk("mid_rst_valid",    32'(res_valid),   32'(0));
        chk("mid_rst_busy",     32'(busy),        32'(0));
        chk("mid_rst_sum",      32'(sum),         32'(0));
        chk("mid_rst_carryout", 32'(carryout),    32'(0));
        chk("mid_rst_overflow", 32'(overflow),    32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

        // Randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            start_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            start_valid = 1'b0;
            n = 0;
            while (!start_ready && n < 60) begin
                res_ready   = 1'($urandom);
                start_valid = 1'($urandom);
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
                @(posedge clk); #1;
                n++;
            end
            start_valid = 1'b0; res_ready = 1'b0;
            if (n >= 60) chk("rand_timeout", 32'(n), 32'(0));
        end

        // WIDTH=8 instance
        sv8 = 1'b1; a8 = 8'h7F; b8 = 8'h80; sub8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0;
        n = 0;
        while (!rv8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_latency",  32'(n),    32'(2));
        chk("w8_sum",      32'(sum8), 32'hFF);
        chk("w8_carryout", 32'(co8),  32'(0));
        chk("w8_overflow", 32'(ov8),  32'(1));
        rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
        chk("w8_idle", 32'(sr8), 32'(1));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
